// File: rtl/quad_enc_gen_if.sv
// Command port of quad_enc_gen: valid/ready handshake carrying direction and step count.
// The master issues step commands; the slave (the generator) accepts them when ready.
interface quad_enc_gen_if #(
   parameter int STEPS_W = 8
) ();
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_dir;
   logic [STEPS_W-1:0] cmd_steps;

   modport master (
      output cmd_valid,
      output cmd_dir,
      output cmd_steps,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_dir,
      input  cmd_steps,
      output cmd_ready
   );
endinterface

// File: rtl/quad_enc_gen.sv
// Quadrature encoder generator: turns step commands into Gray-coded A/B waveforms.
// Define QENC_BOUNCE_EN to emit every edge as new/old/new contact bounce on the changing line.
module quad_enc_gen #(
   parameter int DWELL   = 25000,
   parameter int DWELL_W = 16,
   parameter int STEPS_W = 8
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   quad_enc_gen_if.slave      cmd,
   input  logic               abort,
   output logic               enc_a,
   output logic               enc_b,
   output logic               busy,
   output logic [STEPS_W-1:0] steps_left,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EDGE,
      S_DWELL,
      S_SETTLE
   } state_e;

   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

   state_e             state_q, state_d;
   logic [1:0]         phase_q, phase_d;      // {a, b}
   logic               dir_q, dir_d;
   logic [1:0]         edge_cnt_q, edge_cnt_d;
   logic [STEPS_W-1:0] steps_left_q, steps_left_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               accept;
   logic               abort_hit;
   logic               step_edge;
   logic               step_dir;

   assign cmd.cmd_ready = (state_q == S_IDLE) && !abort;
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   assign abort_hit     = abort && (state_q != S_IDLE);

   // CW walks 00 -> 10 -> 11 -> 01; CCW walks the same ring backwards.
   function automatic logic [1:0] advance(input logic [1:0] ph, input logic cw);
      return cw ? {~ph[0], ph[1]} : {ph[0], ~ph[1]};
   endfunction

   always_comb begin
      // NOTE: every _d starts from its _q so no branch leaves a signal unassigned and infers a latch.
      state_d      = state_q;
      phase_d      = phase_q;
      dir_d        = dir_q;
      edge_cnt_d   = edge_cnt_q;
      steps_left_d = steps_left_q;
      dwell_cnt_d  = dwell_cnt_q;
      done_d       = 1'b0;
      step_edge    = 1'b0;
      step_dir     = dir_q;

      if (abort_hit) begin
         state_d      = S_IDLE;
         steps_left_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  dir_d        = cmd.cmd_dir;
                  steps_left_d = cmd.cmd_steps;
                  edge_cnt_d   = '0;
                  if (cmd.cmd_steps != '0) begin
                     step_edge = 1'b1;
                     step_dir  = cmd.cmd_dir;
                     state_d   = S_EDGE;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
            S_EDGE: begin
               dwell_cnt_d = dwell_cnt_q - 1'b1;
               state_d     = S_DWELL;
            end
            S_DWELL: begin
               if (dwell_cnt_q == '0) begin
                  step_edge = 1'b1;
                  state_d   = S_EDGE;
               end else begin
                  dwell_cnt_d = dwell_cnt_q - 1'b1;
                  // The final dwell ends in SETTLE so done lands exactly DWELL after the last edge.
                  if (dwell_cnt_q == DWELL_W'(1) && steps_left_q == '0) begin
                     state_d = S_SETTLE;
                  end
               end
            end
            S_SETTLE: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      if (step_edge) begin
         phase_d     = advance(phase_q, step_dir);
         dwell_cnt_d = DWELL_LOAD;
         if (edge_cnt_d == 2'd3) begin
            steps_left_d = steps_left_d - 1'b1;
         end
         edge_cnt_d = edge_cnt_d + 2'd1;
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         phase_q      <= 2'b00;
         dir_q        <= 1'b0;
         edge_cnt_q   <= '0;
         steps_left_q <= '0;
         dwell_cnt_q  <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking updates make every flop sample the pre-edge values together.
         state_q      <= state_d;
         phase_q      <= phase_d;
         dir_q        <= dir_d;
         edge_cnt_q   <= edge_cnt_d;
         steps_left_q <= steps_left_d;
         dwell_cnt_q  <= dwell_cnt_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef QENC_BOUNCE_EN
   logic [1:0] line_q, line_d;
   logic [1:0] flip_q, flip_d;
   logic [1:0] bnc_q, bnc_d;

   // Each edge shows new, old, new on the changing line; abort settles onto the logical phase.
   always_comb begin
      line_d = line_q;
      flip_d = flip_q;
      bnc_d  = bnc_q;
      if (abort_hit) begin
         line_d = phase_q;
         bnc_d  = 2'd0;
      end else if (step_edge) begin
         line_d = phase_d;
         flip_d = phase_d ^ phase_q;
         bnc_d  = 2'd2;
      end else if (bnc_q == 2'd2) begin
         line_d = phase_q ^ flip_q;
         bnc_d  = 2'd1;
      end else if (bnc_q == 2'd1) begin
         line_d = phase_q;
         bnc_d  = 2'd0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         line_q <= 2'b00;
         flip_q <= 2'b00;
         bnc_q  <= 2'd0;
      end else begin
         line_q <= line_d;
         flip_q <= flip_d;
         bnc_q  <= bnc_d;
      end
   end

   assign enc_a = line_q[1];
   assign enc_b = line_q[0];
`else
   assign enc_a = phase_q[1];
   assign enc_b = phase_q[0];
`endif

   assign busy       = busy_q;
   assign done       = done_q;
   assign steps_left = steps_left_q;

endmodule
